// File: rtl/rc4_prga_decrypt_if.sv
// Bus bundle for the RC4 PRGA decryptor: run handshake plus the S-memory,
// encrypted-ROM and decrypted-RAM ports.
interface rc4_prga_decrypt_if;
  logic       start;
  logic       done;
  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;
  logic [4:0] enc_addr;
  logic [7:0] enc_q;
  logic [4:0] dec_addr;
  logic [7:0] dec_data;
  logic       dec_wren;

  modport master (
    input  start, s_q, enc_q,
    output done, s_addr, s_data, s_wren, enc_addr, dec_addr, dec_data, dec_wren
  );

  modport slave (
    output start, s_q, enc_q,
    input  done, s_addr, s_data, s_wren, enc_addr, dec_addr, dec_data, dec_wren
  );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator (PRGA) that XORs the keystream onto an encrypted
// message; S is already key-scheduled and lives in an external 2-cycle-read RAM.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  rc4_prga_decrypt_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, LT_SI, RD_SJ, WT_SJ, LT_SJ,
    WR_SI, WR_SJ, RD_F, WT_F, LT_F, WR_OUT, DONE
  } state_t;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t     state_r;
  logic [7:0] i_r;
  logic [7:0] j_r;
  logic [7:0] k_r;
  logic [7:0] si_r;
  logic [7:0] sj_r;
  logic [7:0] f_r;
  logic [7:0] e_r;

  // Sequencer: each transition also loads the registered outputs of the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      i_r          <= 8'd0;
      j_r          <= 8'd0;
      k_r          <= 8'd0;
      si_r         <= 8'd0;
      sj_r         <= 8'd0;
      f_r          <= 8'd0;
      e_r          <= 8'd0;
      bus.done     <= 1'b0;
      bus.s_addr   <= 8'd0;
      bus.s_data   <= 8'd0;
      bus.s_wren   <= 1'b0;
      bus.enc_addr <= 5'd0;
      bus.dec_addr <= 5'd0;
      bus.dec_data <= 8'd0;
      bus.dec_wren <= 1'b0;
    end else begin
      bus.s_wren   <= 1'b0;
      bus.dec_wren <= 1'b0;
      // done follows the DONE state one cycle late, so it drops the cycle after leaving.
      bus.done     <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          j_r <= 8'd0;
          k_r <= 8'd0;
          if (bus.start) begin
            i_r        <= 8'd1;
            bus.s_addr <= 8'd1;
            state_r    <= RD_SI;
          end else begin
            i_r     <= 8'd0;
            state_r <= IDLE;
          end
        end
        RD_SI: state_r <= WT_SI;
        WT_SI: state_r <= LT_SI;
        LT_SI: begin
          si_r       <= bus.s_q;
          j_r        <= j_r + bus.s_q;
          bus.s_addr <= j_r + bus.s_q;
          state_r    <= RD_SJ;
        end
        RD_SJ: state_r <= WT_SJ;
        WT_SJ: state_r <= LT_SJ;
        LT_SJ: begin
          sj_r       <= bus.s_q;
          bus.s_addr <= i_r;
          bus.s_data <= bus.s_q;
          bus.s_wren <= 1'b1;
          state_r    <= WR_SI;
        end
        // When i == j this second write repeats the first, so S is left unchanged.
        WR_SI: begin
          bus.s_addr <= j_r;
          bus.s_data <= si_r;
          bus.s_wren <= 1'b1;
          state_r    <= WR_SJ;
        end
        WR_SJ: begin
          bus.s_addr   <= si_r + sj_r;
          bus.enc_addr <= k_r[4:0];
          state_r      <= RD_F;
        end
        RD_F: state_r <= WT_F;
        WT_F: state_r <= LT_F;
        LT_F: begin
          f_r          <= bus.s_q;
          e_r          <= bus.enc_q;
          bus.dec_addr <= k_r[4:0];
          bus.dec_data <= bus.s_q ^ bus.enc_q;
          bus.dec_wren <= 1'b1;
          state_r      <= WR_OUT;
        end
        WR_OUT: begin
          if (k_r == LAST_K) begin
            state_r <= DONE;
          end else begin
            k_r        <= k_r + 8'd1;
            i_r        <= i_r + 8'd1;
            bus.s_addr <= i_r + 8'd1;
            state_r    <= RD_SI;
          end
        end
        DONE: begin
          if (bus.start) begin
            state_r <= DONE;
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench: behavioural RAM/ROM models around the decryptor and a
// software RC4 PRGA reference computed from a snapshot of S before each run.
module tb_rc4_prga_decrypt;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rc4_prga_decrypt_if bus ();
  rc4_prga_decrypt #(.MSG_LEN(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] s_mem [256];
  logic [7:0] load_s [256];
  logic       load_req = 1'b0;
  logic [7:0] enc_mem [N];
  logic [7:0] dec_mem [N];
  logic [7:0] s_a1 = 8'd0;
  logic [4:0] e_a1 = 5'd0;
  logic [7:0] sq = 8'd0;
  logic [7:0] eq = 8'd0;
  int         wr_count = 0;
  int         dec_count = 0;
  logic [7:0] wr_a_log [1024];
  logic [7:0] wr_d_log [1024];
  logic [4:0] dec_a_log [1024];

  assign bus.s_q   = sq;
  assign bus.enc_q = eq;

  // Memories: writes commit on the edge, reads return data two edges after the address.
  always @(posedge clk) begin
    if (load_req) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= load_s[x];
      for (int x = 0; x < N; x++) dec_mem[x] <= 8'h00;
    end else begin
      if (bus.s_wren) begin
        s_mem[bus.s_addr]       <= bus.s_data;
        wr_a_log[wr_count % 1024] <= bus.s_addr;
        wr_d_log[wr_count % 1024] <= bus.s_data;
        wr_count                <= wr_count + 1;
      end
      if (bus.dec_wren) begin
        dec_mem[bus.dec_addr]       <= bus.dec_data;
        dec_a_log[dec_count % 1024] <= bus.dec_addr;
        dec_count                   <= dec_count + 1;
      end
    end
    s_a1 <= bus.s_addr;
    sq   <= s_mem[s_a1];
    e_a1 <= bus.enc_addr;
    eq   <= enc_mem[e_a1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_s [256];
  logic [7:0] exp_dec [N];
  logic [7:0] exp_wa [2*N];
  logic [7:0] exp_wd [2*N];
  int         last_wbase;

  task automatic model_run();
    int i = 0;
    int j = 0;
    logic [7:0] t;
    for (int k = 0; k < N; k++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      exp_wa[2*k]   = 8'(i);
      exp_wd[2*k]   = m_s[j];
      exp_wa[2*k+1] = 8'(j);
      exp_wd[2*k+1] = m_s[i];
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      exp_dec[k] = m_s[(m_s[i] + m_s[j]) % 256] ^ enc_mem[k];
    end
  endtask

  task automatic do_load();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic random_perm();
    int r;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) load_s[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(0, x);
      t = load_s[x];
      load_s[x] = load_s[r];
      load_s[r] = t;
    end
    for (int x = 0; x < N; x++) enc_mem[x] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_and_check(input string name, input bit toggle, input bit hold);
    int wbase;
    int dbase;
    int cycles;
    int nbad;
    wbase = wr_count;
    dbase = dec_count;
    last_wbase = wbase;
    for (int x = 0; x < 256; x++) m_s[x] = s_mem[x];
    model_run();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    cycles = 0;
    while (!bus.done && cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (toggle) bus.start = (cycles < 12*N - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check({name, "_latency"}, cycles, 12*N + 1);
    check({name, "_s_writes"}, wr_count - wbase, 2*N);
    check({name, "_dec_writes"}, dec_count - dbase, N);
    for (int w = 0; w < 2*N; w++) begin
      check({name, "_wr_addr"}, wr_a_log[(wbase + w) % 1024], exp_wa[w]);
      check({name, "_wr_data"}, wr_d_log[(wbase + w) % 1024], exp_wd[w]);
    end
    for (int k = 0; k < N; k++) begin
      check({name, "_dec_order"}, dec_a_log[(dbase + k) % 1024], 32'(k));
      check({name, "_dec_byte"}, dec_mem[k], exp_dec[k]);
    end
    nbad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) nbad++;
    check({name, "_final_s_mismatches"}, nbad, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_done"}, bus.done, 0);
    check({name, "_s_wren"}, bus.s_wren, 0);
    check({name, "_dec_wren"}, bus.dec_wren, 0);
    check({name, "_s_addr"}, bus.s_addr, 0);
    check({name, "_s_data"}, bus.s_data, 0);
    check({name, "_enc_addr"}, bus.enc_addr, 0);
    check({name, "_dec_addr"}, bus.dec_addr, 0);
    check({name, "_dec_data"}, bus.dec_data, 0);
  endtask

  initial begin
    int wb;
    int db;
    int bound;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    // Identity S with the known first two message bytes
    for (int x = 0; x < 256; x++) load_s[x] = 8'(x);
    for (int x = 0; x < N; x++) enc_mem[x] = 8'($urandom_range(0, 255));
    enc_mem[0] = 8'h02;
    enc_mem[1] = 8'hA5;
    do_load();
    run_and_check("identity", 1'b0, 1'b0);
    check("id_dec0", dec_mem[0], 32'h00);
    check("id_dec1", dec_mem[1], 32'hA0);
    check("id_w0_addr", wr_a_log[last_wbase % 1024], 32'd1);
    check("id_w0_data", wr_d_log[last_wbase % 1024], 32'd1);
    check("id_w1_addr", wr_a_log[(last_wbase + 1) % 1024], 32'd1);
    check("id_w1_data", wr_d_log[(last_wbase + 1) % 1024], 32'd1);
    check("id_w2_addr", wr_a_log[(last_wbase + 2) % 1024], 32'd2);
    check("id_w2_data", wr_d_log[(last_wbase + 2) % 1024], 32'd3);
    check("id_w3_addr", wr_a_log[(last_wbase + 3) % 1024], 32'd3);
    check("id_w3_data", wr_d_log[(last_wbase + 3) % 1024], 32'd2);
    @(posedge clk);
    #1;
    check("id_done_clear", bus.done, 0);

    // Random S with start toggling during the run
    random_perm();
    do_load();
    run_and_check("random_toggle", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("rt_done_clear", bus.done, 0);

    // start held high through DONE
    random_perm();
    do_load();
    run_and_check("hold", 1'b0, 1'b1);
    wb = wr_count;
    db = dec_count;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("hold_done_high", bus.done, 1);
    end
    check("hold_no_s_writes", wr_count - wb, 0);
    check("hold_no_dec_writes", dec_count - db, 0);
    @(negedge clk) bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_done_clear", bus.done, 0);

    // Reset during the first S write of byte 3, then rerun on the partly swapped S
    random_perm();
    do_load();
    wb = wr_count;
    db = dec_count;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    bound = 0;
    while (!(bus.s_wren && (wr_count - wb) == 6) && bound < 1000) begin
      @(negedge clk);
      bound++;
    end
    check("abort_reached_wr_si3", (bound < 1000) ? 1 : 0, 1);
    #1 reset_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_s_writes", wr_count - wb, 6);
    check("abort_dec_writes", dec_count - db, 3);
    @(negedge clk) reset_n = 1'b1;
    run_and_check("after_reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rc4_prga_decrypt.md
RC4_PRGA_DECRYPT -- requirements
Module: rc4_prga_decrypt

Interface
REQ-001 Parameter MSG_LEN, default 32: number of message bytes processed per run (1..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 done  output  1  run complete; level held in DONE.
REQ-006 s_addr  output  8  S-memory address.
REQ-007 s_data  output  8  S-memory write data.
REQ-008 s_wren  output  1  S-memory write enable.
REQ-009 s_q  input  8  S-memory read data.
REQ-010 enc_addr  output  5  encrypted-message ROM address.
REQ-011 enc_q  input  8  encrypted-message ROM data.
REQ-012 dec_addr  output  5  decrypted-message RAM address.
REQ-013 dec_data  output  8  decrypted-message RAM write data.
REQ-014 dec_wren  output  1  decrypted-message RAM write enable.

Function
REQ-015 Block SHALL run the RC4 PRGA over an S array already shuffled by key scheduling: i=0, j=0; for k=0..MSG_LEN-1: i=i+1, j=j+S[i], swap S[i]/S[j], f=S[S[i]+S[j]], dec[k]=f XOR enc[k].
REQ-016 All index arithmetic (i, j, k, S[i]+S[j]) SHALL be 8-bit modulo 256; i=255 wraps to 0, j wraps silently.
REQ-017 Memory timing: read data is valid in the second cycle after its address is driven (drive, wait, latch); the block SHALL sample s_q and enc_q only in LATCH states.
REQ-018 States and order: IDLE, RD_SI, WT_SI, LT_SI, RD_SJ, WT_SJ, LT_SJ, WR_SI, WR_SJ, RD_F, WT_F, LT_F, WR_OUT, DONE.
REQ-019 IDLE: i, j, k cleared; start=1 -> RD_SI, else stay.
REQ-020 RD_SI: i<=i+1; s_addr=i+1, s_wren=0.
REQ-021 LT_SI: si<=s_q; j<=j+s_q.
REQ-022 RD_SJ: s_addr=j (updated value), s_wren=0; LT_SJ: sj<=s_q.
REQ-023 WR_SI: s_addr=i, s_data=sj, s_wren=1; WR_SJ: s_addr=j, s_data=si, s_wren=1.
REQ-024 When i==j, both writes SHALL still occur with identical address and data, leaving S unchanged.
REQ-025 RD_F: s_addr=si+sj, s_wren=0, enc_addr=k; LT_F: f<=s_q, e<=enc_q.
REQ-026 WR_OUT: dec_addr=k, dec_data=f XOR e, dec_wren=1; if k==MSG_LEN-1 -> DONE, else k<=k+1 -> RD_SI.
REQ-027 Throughput: exactly 12 cycles per byte; done rises 12*MSG_LEN+1 cycles after the clock edge that samples start=1.
REQ-028 s_wren SHALL be 1 only in WR_SI/WR_SJ; dec_wren SHALL be 1 only in WR_OUT; both single-cycle pulses.
REQ-029 DONE: done=1; stay while start=1; start=0 -> IDLE (done=0 next cycle).
REQ-030 start toggling outside IDLE/DONE SHALL be ignored.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE and done=0, s_wren=0, dec_wren=0, all addresses/data outputs 0, i=j=k=0, si=sj=f=e=0.
REQ-032 Reset mid-run SHALL abort with no further memory writes; after release a new start begins at k=0 with i=j=0.

Verification
REQ-033 S[x]=x, enc[0]=0x02, start pulse -> s_addr=1 read, j=1, writes S[1]=1 twice, f read at addr 2, dec[0]=0x00.
REQ-034 Same run, enc[1]=0xA5 -> S[2]=3, S[3]=2 after swap, f read at addr 5, dec[1]=0xA0.
REQ-035 MSG_LEN=32, random shuffled S vs software RC4 model -> all 32 dec bytes and final S match; done at cycle 385.
REQ-036 reset_n pulsed low during WR_SI of byte 3 -> s_wren=0 that cycle, outputs 0, IDLE; rerun from start produces correct dec[0..].
REQ-037 start held high through DONE -> done stays 1, no writes; start=0 -> IDLE next cycle, done=0.
REQ-038 start asserted mid-run -> no effect on cycle count or outputs.
